focal_sum_stream: RTL and testbench
===================================

# focal_sum_stream

Streaming, parametrised row focal-sum engine for the tiny SPU datapath. Accepts raster pixels one per handshake and emits, for every fully populated horizontal window of `WIN` pixels inside a row of `ROW_LEN` pixels, the sum of that window. The sum is either wrapped or saturated. With defaults (`WIN=3`, `ROW_LEN=4`), a 4-pixel row A,B,C,D yields exactly two outputs: A+B+C, then B+C+D. It sits between the pixel input deserialiser and the result serialiser, and replaces the fixed 4-in/2-out combinational row-sum operator.

## Interface
Parameters:
- `DATA_W`, default 4: pixel width, unsigned.
- `WIN`, default 3: window length. Legal range 2..`ROW_LEN`.
- `ROW_LEN`, default 4: pixels per row. Must be at least 2.
- `SUM_W`, default 4: output sum width.
- `SATURATE`, default 0:
  - 0: wrap the sum modulo 2^`SUM_W`.
  - 1: clamp the sum at 2^`SUM_W`−1.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous restart: empties the window, resets the column counter and drops any pending output.
- `in_valid`  in  1  input pixel valid.
- `in_ready`  out  1  block can accept a pixel.
- `in_data`  in  `DATA_W`  pixel value.
- `out_valid`  out  1  `out_data` holds a result.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  `SUM_W`  window sum.
- `out_last`  out  1  result is the final window of its row.
- `out_ovf`  out  1  exact sum did not fit in `SUM_W` bits.

## Operation
- Input accept: `acc = in_valid & in_ready`.
- Output release: `rel = out_valid & out_ready`.
- Column counter `col` (0..`ROW_LEN`−1):
  - Increments on each `acc`.
  - Wraps to 0 after `ROW_LEN`−1. Rows are implicit; there is no start-of-row input.
- Tap register: holds the last `WIN`−1 accepted pixels of the current row. It shifts on `acc`. Taps filled in the previous row are never used; window validity depends only on `col`.
- On `acc` with `col ≥ WIN`−1:
  - Compute the exact sum of the taps plus `in_data` at full width `DATA_W`+clog2(`WIN`).
  - Load the output register with `out_valid=1` and `out_last = (col == ROW_LEN−1)`.
- On `acc` with `col < WIN`−1: no output is produced.
- Width reduction:
  - `out_ovf = 1` iff the exact sum exceeds 2^`SUM_W`−1.
  - `out_data` is the low `SUM_W` bits when `SATURATE=0`, or all-ones on overflow when `SATURATE=1`.
  - If `SUM_W` is at least the full width, `out_ovf` is constantly 0.
- Output count: exactly `ROW_LEN`−`WIN`+1 results per row.
- Flow control: `in_ready = ~out_valid | out_ready` (combinational). This gives a single output buffer with pass-through on release.
- Simultaneous `acc` and `rel`: the old result leaves and the new result loads in the same edge, with no bubble.
- `clear`:
  - Priority over `acc`. A pixel presented in the same cycle is discarded, but it still counts as handshaken because `in_ready` does not depend on `clear`.
  - Next state: `col=0`, taps=0, `out_valid=0`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_ovf=0`, `col=0`, taps=0. Hence `in_ready=1` while idle after reset.
- Latency: the result appears on the `out_*` registers one cycle after the accept edge of the window's final pixel.
- Throughput: one pixel per cycle while `out_ready` is held high.
- Backpressure: while `out_valid=1` and `out_ready=0`:
  - `in_ready=0`.
  - `out_data`, `out_last` and `out_ovf` are held stable.
  - `col` and the taps are frozen.
- Reset asserted mid-row: all state returns to the reset values immediately. The first pixel after deassertion is column 0.
- `out_valid` never drops without `rel` or `clear`.

## Structure
- Shared package/header `spu_pkg`: the clog2 helper, the full-sum-width constant function, and the mode constants `SUM_WRAP=0` and `SUM_SAT=1`.
- Sub-module `focal_tap_shift`:
  - Parametrised on `DATA_W` and depth `WIN`−1.
  - Shift register with enable and synchronous clear.
  - Exposes all taps as a flat vector.
- The adder tree, width reducer, column counter and output register stay in `focal_sum_stream`.

## Test plan
All scenarios use defaults unless stated otherwise.
- Basic row: stream 1,2,3,4 with `out_ready=1` → outputs 6 (last=0), then 9 (last=1), `ovf=0`. Next row 0,0,0,1 → outputs 0, then 1, with no leakage from the previous row.
- Wrap overflow: stream 7,7,7,0 → 5 (`ovf=1`), then 14 (`ovf=0`).
- Saturate (`SATURATE=1`): stream 7,7,7,0 → 15 (`ovf=1`), then 14 (`ovf=0`).
- Backpressure: hold `out_ready=0` after the first result → `in_ready=0`, output held at 6 for 5 cycles. Release → 9 follows, and no pixel is lost or duplicated.
- Clear/reset mid-row: after 1,2, assert `clear` → feeding 5,5,5,5 gives 15, then 15. Repeat with `rst_n` pulsed low instead → same results, and all outputs read 0 during reset.
- Generic (`WIN=4`, `ROW_LEN=8`, `SUM_W=6`): stream 1..8 → 10, 14, 18, 22, 26, with `last` asserted only on 26.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared SPU datapath helpers: width arithmetic and sum-reduction mode codes.
package spu_pkg;

    localparam int SUM_WRAP = 0;
    localparam int SUM_SAT  = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width that holds WIN pixels of DATA_W bits summed without loss.
    function automatic int full_sum_w(input int data_w, input int win);
        return data_w + clog2(win);
    endfunction

endpackage

// File: rtl/focal_sum_stream_if.sv
// Pixel-in / window-sum-out handshake bundle for focal_sum_stream.
interface focal_sum_stream_if #(
    parameter int DATA_W = 4,
    parameter int SUM_W  = 4
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_data;
    logic              out_last;
    logic              out_ovf;

    modport master (
        output clear, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_ovf
    );

    modport slave (
        input  clear, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_ovf
    );
endinterface

// File: rtl/focal_tap_shift.sv
// Pixel tap line: shift register with enable and synchronous clear, taps exposed flat.
module focal_tap_shift #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [DATA_W-1:0]        din_i,
    output logic [DEPTH*DATA_W-1:0]  taps_o
);
    logic [DEPTH-1:0][DATA_W-1:0] tap_q;

    // tap_q[0] is the most recently accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '0;
        end else if (clr_i) begin
            tap_q <= '0;
        end else if (en_i) begin
            tap_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
        end
    end

    assign taps_o = tap_q;
endmodule

// File: rtl/focal_sum_stream.sv
// Streaming row focal-sum: emits the sum of every full WIN-pixel window within a ROW_LEN row.
module focal_sum_stream
    import spu_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int WIN      = 3,
    parameter int ROW_LEN  = 4,
    parameter int SUM_W    = 4,
    parameter int SATURATE = SUM_WRAP
) (
    input  logic              clk,
    input  logic              rst_n,
    focal_sum_stream_if.slave bus
);
    localparam int FW    = full_sum_w(DATA_W, WIN);
    localparam int CW    = (clog2(ROW_LEN) < 1) ? 1 : clog2(ROW_LEN);
    localparam int DEPTH = WIN - 1;

    logic [CW-1:0]           col_q, col_d;
    logic [DEPTH*DATA_W-1:0] taps;
    logic [FW-1:0]           sum_full;
    logic [SUM_W-1:0]        sum_red;
    logic                    sum_ovf;
    logic                    out_valid_q, out_valid_d;
    logic [SUM_W-1:0]        out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    out_ovf_q, out_ovf_d;
    logic                    in_ready, acc, rel, emit, row_end;

    // Single output buffer; a release frees the slot in the same cycle.
    assign in_ready = ~out_valid_q | bus.out_ready;
    assign acc      = bus.in_valid & in_ready;
    assign rel      = out_valid_q & bus.out_ready;
    assign row_end  = (col_q == CW'(ROW_LEN - 1));
    // Taps older than the current row only sit in the window while col < WIN-1.
    assign emit     = acc & (col_q >= CW'(WIN - 1));

    focal_tap_shift #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_taps (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (acc & ~bus.clear),
        .clr_i  (bus.clear),
        .din_i  (bus.in_data),
        .taps_o (taps)
    );

    always_comb begin
        sum_full = FW'(bus.in_data);
        for (int i = 0; i < DEPTH; i++) begin
            sum_full = sum_full + FW'(taps[i*DATA_W +: DATA_W]);
        end
    end

    generate
        if (SUM_W >= FW) begin : g_wide
            assign sum_ovf = 1'b0;
            assign sum_red = SUM_W'(sum_full);
        end else begin : g_narrow
            assign sum_ovf = |sum_full[FW-1:SUM_W];
            assign sum_red = (SATURATE == SUM_SAT && sum_ovf) ? '1 : sum_full[SUM_W-1:0];
        end
    endgenerate

    always_comb begin
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_ovf_d   = out_ovf_q;
        if (bus.clear) begin
            col_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            if (acc) col_d = row_end ? '0 : col_q + CW'(1);
            if (emit) begin
                out_valid_d = 1'b1;
                out_data_d  = sum_red;
                out_last_d  = row_end;
                out_ovf_d   = sum_ovf;
            end else if (rel) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_focal_sum_stream.sv
// Directed bench: default, saturating and WIN=4/ROW_LEN=8 instances share one stimulus stream.
module tb_focal_sum_stream;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [3:0] in_data = '0;
    int         errs = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    focal_sum_stream_if #(.DATA_W(4), .SUM_W(4)) b0 ();
    focal_sum_stream_if #(.DATA_W(4), .SUM_W(4)) b1 ();
    focal_sum_stream_if #(.DATA_W(4), .SUM_W(6)) b2 ();

    assign b0.clear = clear;  assign b0.in_valid = in_valid;
    assign b0.in_data = in_data;  assign b0.out_ready = out_ready;
    assign b1.clear = clear;  assign b1.in_valid = in_valid;
    assign b1.in_data = in_data;  assign b1.out_ready = out_ready;
    assign b2.clear = clear;  assign b2.in_valid = in_valid;
    assign b2.in_data = in_data;  assign b2.out_ready = out_ready;

    focal_sum_stream dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    focal_sum_stream #(.SATURATE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    focal_sum_stream #(.WIN(4), .ROW_LEN(8), .SUM_W(6)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic out0(input string tag, input int d, input logic l, input logic o);
        chk({tag, ".valid"}, b0.out_valid, 1'b1);
        chk({tag, ".data"},  b0.out_data, d);
        chk({tag, ".last"},  b0.out_last, l);
        chk({tag, ".ovf"},   b0.out_ovf, o);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic px(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", b0.out_valid, 1'b0);
        chk("rst.data",  b0.out_data, 4'd0);
        chk("rst.last",  b0.out_last, 1'b0);
        chk("rst.ovf",   b0.out_ovf, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", b0.in_ready, 1'b1);

        // basic row, then a row that must not see the previous taps
        px(4'd1); chk("row1.p1.valid", b0.out_valid, 1'b0);
        px(4'd2); chk("row1.p2.valid", b0.out_valid, 1'b0);
        px(4'd3); out0("row1.w0", 6, 1'b0, 1'b0);
        px(4'd4); out0("row1.w1", 9, 1'b1, 1'b0);
        px(4'd0); chk("row2.p1.valid", b0.out_valid, 1'b0);
        px(4'd0); chk("row2.p2.valid", b0.out_valid, 1'b0);
        px(4'd0); out0("row2.w0", 0, 1'b0, 1'b0);
        px(4'd1); out0("row2.w1", 1, 1'b1, 1'b0);

        // wrap vs saturate
        px(4'd7); px(4'd7); px(4'd7);
        out0("wrap.w0", 5, 1'b0, 1'b1);
        chk("sat.w0.data", b1.out_data, 4'd15);
        chk("sat.w0.ovf",  b1.out_ovf, 1'b1);
        px(4'd0);
        out0("wrap.w1", 14, 1'b1, 1'b0);
        chk("sat.w1.data", b1.out_data, 4'd14);
        chk("sat.w1.ovf",  b1.out_ovf, 1'b0);

        // backpressure: hold 6 for five cycles while the next pixel waits
        px(4'd1); px(4'd2);
        out_ready = 1'b0;
        px(4'd3);
        out0("bp.first", 6, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'd4;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp.in_ready", b0.in_ready, 1'b0);
            chk("bp.hold.data", b0.out_data, 4'd6);
            chk("bp.hold.valid", b0.out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", b0.in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        out0("bp.next", 9, 1'b1, 1'b0);
        cyc();
        chk("bp.no_dup.valid", b0.out_valid, 1'b0);

        // clear mid-row, with a pixel presented in the clear cycle
        px(4'd1); px(4'd2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd9;
        cyc();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr.valid", b0.out_valid, 1'b0);
        px(4'd5); px(4'd5);
        chk("clr.p2.valid", b0.out_valid, 1'b0);
        px(4'd5); out0("clr.w0", 15, 1'b0, 1'b0);
        px(4'd5); out0("clr.w1", 15, 1'b1, 1'b0);

        // asynchronous reset mid-row
        px(4'd1); px(4'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid", b0.out_valid, 1'b0);
        chk("arst.data",  b0.out_data, 4'd0);
        chk("arst.last",  b0.out_last, 1'b0);
        chk("arst.ovf",   b0.out_ovf, 1'b0);
        cyc();
        rst_n = 1'b1;
        px(4'd5); px(4'd5);
        chk("arst.p2.valid", b0.out_valid, 1'b0);
        px(4'd5); out0("arst.w0", 15, 1'b0, 1'b0);
        px(4'd5); out0("arst.w1", 15, 1'b1, 1'b0);

        // generic instance: WIN=4, ROW_LEN=8, SUM_W=6
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            px(4'(k));
            if (k < 4) begin
                chk("gen.fill.valid", b2.out_valid, 1'b0);
            end else begin
                chk("gen.valid", b2.out_valid, 1'b1);
                chk("gen.data",  b2.out_data, 4*k - 6);
                chk("gen.last",  b2.out_last, (k == 8));
                chk("gen.ovf",   b2.out_ovf, 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
